// File: rtl/stdp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stdp_pkg
// Purpose  : Shared widths, the invalid-age marker and the FSM state encoding
//            for the STDP pair scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package stdp_pkg;

  localparam int TS_W = 8;
  localparam logic [TS_W-1:0] AGE_INVALID = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_REQ  = 3'd2,
    ST_RESP = 3'd3,
    ST_WB   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stdp_age_tracker.sv
`default_nettype none
// ============================================================================
// Module   : stdp_age_tracker
// Purpose  : Saturating per-input spike age. Cleared by a presynaptic spike on
//            a tick, otherwise incremented per tick until it reaches the
//            invalid marker.
// Revision : 1.0 - initial release
// ============================================================================
module stdp_age_tracker
  import stdp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            pre_fire,
  output logic [TS_W-1:0] age_next
);

  logic [TS_W-1:0] age_q, age_d;

  // Next age: a spike wins over aging; saturate at the invalid marker
  always_comb begin
    age_d = age_q;
    if (tick) begin
      if (pre_fire)
        age_d = '0;
      else if (age_q != AGE_INVALID)
        age_d = age_q + 1'b1;
    end
  end

  // Age register, invalid out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) age_q <= AGE_INVALID;
    else     age_q <= age_d;
  end

  // Post-update value so a same-tick pre spike pairs with age 0
  assign age_next = age_d;

endmodule
`default_nettype wire

// File: rtl/stdp_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : stdp_pair_scheduler
// Purpose  : Tracks pre/post spike timing, and on each post event scans a
//            frozen snapshot of pre ages, issuing one pair request per
//            eligible input to an external STDP engine and writing the
//            returned weight back into the local weight table.
// Revision : 1.0 - initial release
// ============================================================================
module stdp_pair_scheduler
  import stdp_pkg::*;
#(
  parameter int N_PRE  = 8,
  parameter int WINDOW = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [N_PRE-1:0]         pre_fire,
  input  logic                     post_fire,
  input  logic                     wload_en,
  input  logic [$clog2(N_PRE)-1:0] wload_addr,
  input  logic [7:0]               wload_data,
  output logic                     wload_ready,
  input  logic [$clog2(N_PRE)-1:0] rd_addr,
  output logic [7:0]               rd_data,
  output logic                     req_valid,
  output logic [7:0]               pre_spike,
  output logic [7:0]               post_spike,
  output logic [7:0]               weight,
  output logic [7:0]               neuron_number,
  input  logic                     stdp_wait,
  input  logic                     resp_valid,
  input  logic [7:0]               updated_weight,
  output logic                     busy,
  output logic                     overflow
);

  localparam int IW = $clog2(N_PRE);
  localparam logic [IW-1:0]   IDX_LAST = IW'(N_PRE - 1);
  localparam logic [TS_W-1:0] WIN      = TS_W'(WINDOW);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TS_W-1:0] now_q, now_d;
  logic [TS_W-1:0] post_ts_q, post_ts_d, pend_ts_q, pend_ts_d;
  logic [TS_W-1:0] age_nxt   [N_PRE];
  logic [TS_W-1:0] snap_q    [N_PRE];
  logic [TS_W-1:0] snap_d    [N_PRE];
  logic [TS_W-1:0] pend_age_q[N_PRE];
  logic [TS_W-1:0] pend_age_d[N_PRE];
  logic [7:0]      w_q       [N_PRE];
  logic [7:0]      w_d       [N_PRE];
  logic            pend_q, pend_d, ovf_q, ovf_d;
  logic [7:0]      cap_q, cap_d;
  logic            req_valid_q, req_valid_d, busy_q, busy_d, ready_q, ready_d;
  logic [7:0]      pre_spike_q, pre_spike_d, post_spike_q, post_spike_d;
  logic [7:0]      weight_q, weight_d, nn_q, nn_d;
  logic            post_ev;
  logic [TS_W-1:0] post_ts_now;

  genvar gi;
  generate
    for (gi = 0; gi < N_PRE; gi++) begin : g_age
      stdp_age_tracker u_age (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .pre_fire (pre_fire[gi]),
        .age_next (age_nxt[gi])
      );
    end
  endgenerate

  assign post_ev     = tick & post_fire;
  assign post_ts_now = now_q + 1'b1;

  // Next-state, snapshot/pending bookkeeping, weight table and output staging
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    now_d        = tick ? post_ts_now : now_q;
    post_ts_d    = post_ts_q;
    pend_ts_d    = pend_ts_q;
    snap_d       = snap_q;
    pend_age_d   = pend_age_q;
    w_d          = w_q;
    pend_d       = pend_q;
    ovf_d        = ovf_q;
    cap_d        = cap_q;
    pre_spike_d  = pre_spike_q;
    post_spike_d = post_spike_q;
    weight_d     = weight_q;
    nn_d         = nn_q;

    // Post events arriving while busy park in a one-deep buffer
    if (state_q != ST_IDLE && post_ev) begin
      if (!pend_q) begin
        pend_d     = 1'b1;
        pend_age_d = age_nxt;
        pend_ts_d  = post_ts_now;
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (wload_en) w_d[wload_addr] = wload_data;
        if (pend_q) begin
          // Serve the parked event; a coincident new event takes its slot
          state_d   = ST_SCAN;
          idx_d     = '0;
          snap_d    = pend_age_q;
          post_ts_d = pend_ts_q;
          pend_d    = post_ev;
          if (post_ev) begin
            pend_age_d = age_nxt;
            pend_ts_d  = post_ts_now;
          end
        end else if (post_ev) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          snap_d    = age_nxt;
          post_ts_d = post_ts_now;
        end
      end
      ST_SCAN: begin
        if (snap_q[idx_q] <= WIN) begin
          state_d      = ST_REQ;
          pre_spike_d  = post_ts_q - snap_q[idx_q];
          post_spike_d = post_ts_q;
          weight_d     = w_q[idx_q];
          nn_d         = {{(8-IW){1'b0}}, idx_q};
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_REQ: begin
        if (!stdp_wait) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_valid) begin
          cap_d   = updated_weight;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        w_d[idx_q] = cap_q;
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_valid_d = (state_d == ST_REQ);
    busy_d      = (state_d != ST_IDLE);
    ready_d     = (state_d == ST_IDLE);
  end

  // State, tables and registered outputs; reset abandons any transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      now_q        <= '0;
      post_ts_q    <= '0;
      pend_ts_q    <= '0;
      pend_q       <= 1'b0;
      ovf_q        <= 1'b0;
      cap_q        <= '0;
      req_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      pre_spike_q  <= '0;
      post_spike_q <= '0;
      weight_q     <= '0;
      nn_q         <= '0;
      for (int i = 0; i < N_PRE; i++) begin
        snap_q[i]     <= AGE_INVALID;
        pend_age_q[i] <= AGE_INVALID;
        w_q[i]        <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      now_q        <= now_d;
      post_ts_q    <= post_ts_d;
      pend_ts_q    <= pend_ts_d;
      pend_q       <= pend_d;
      ovf_q        <= ovf_d;
      cap_q        <= cap_d;
      req_valid_q  <= req_valid_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      pre_spike_q  <= pre_spike_d;
      post_spike_q <= post_spike_d;
      weight_q     <= weight_d;
      nn_q         <= nn_d;
      snap_q       <= snap_d;
      pend_age_q   <= pend_age_d;
      w_q          <= w_d;
    end
  end

  assign rd_data       = w_q[rd_addr];
  assign wload_ready   = ready_q;
  assign req_valid     = req_valid_q;
  assign busy          = busy_q;
  assign overflow      = ovf_q;
  assign pre_spike     = pre_spike_q;
  assign post_spike    = post_spike_q;
  assign weight        = weight_q;
  assign neuron_number = nn_q;

endmodule
`default_nettype wire

// File: tb/tb_stdp_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_stdp_pair_scheduler
// Purpose  : Directed self-checking bench for stdp_pair_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stdp_pair_scheduler;

  logic       clk, rst, tick, post_fire, wload_en, wload_ready;
  logic [7:0] pre_fire;
  logic [2:0] wload_addr, rd_addr;
  logic [7:0] wload_data, rd_data, pre_spike, post_spike, weight, neuron_number;
  logic       req_valid, stdp_wait, resp_valid, busy, overflow;
  logic [7:0] updated_weight;

  int vectors     = 0;
  int miscompares = 0;
  int req_cnt     = 0;

  stdp_pair_scheduler #(.N_PRE(8), .WINDOW(20)) dut (
    .clk(clk), .rst(rst), .tick(tick), .pre_fire(pre_fire), .post_fire(post_fire),
    .wload_en(wload_en), .wload_addr(wload_addr), .wload_data(wload_data),
    .wload_ready(wload_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .req_valid(req_valid), .pre_spike(pre_spike), .post_spike(post_spike),
    .weight(weight), .neuron_number(neuron_number), .stdp_wait(stdp_wait),
    .resp_valid(resp_valid), .updated_weight(updated_weight),
    .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted requests
  always @(posedge clk) if (req_valid && !stdp_wait) req_cnt <= req_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] pre, input logic post);
    tick = 1'b1; pre_fire = pre; post_fire = post;
    @(posedge clk); #1;
    tick = 1'b0; pre_fire = '0; post_fire = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0);
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    wload_en = 1'b1; wload_addr = a; wload_data = d;
    @(posedge clk); #1;
    wload_en = 1'b0;
  endtask

  task automatic wait_req(input string tg);
    for (int n = 0; n < 64 && !req_valid; n++) begin
      @(posedge clk); #1;
    end
    check({tg, "_req_seen"}, {7'd0, req_valid}, 8'd1);
  endtask

  task automatic wait_idle(input string tg);
    for (int n = 0; n < 64 && busy; n++) begin
      @(posedge clk); #1;
    end
    check({tg, "_idle"}, {7'd0, busy}, 8'd0);
  endtask

  task automatic serve(input string tg, input logic [7:0] e_pre, input logic [7:0] e_post,
                       input logic [7:0] e_nn, input logic [7:0] e_w,
                       input logic [7:0] rv, input int hold);
    wait_req(tg);
    check({tg, "_pre"},  pre_spike,     e_pre);
    check({tg, "_post"}, post_spike,    e_post);
    check({tg, "_nn"},   neuron_number, e_nn);
    check({tg, "_w"},    weight,        e_w);
    for (int k = 1; k < hold; k++) begin
      @(posedge clk); #1;
      check({tg, "_hold_valid"}, {7'd0, req_valid}, 8'd1);
      check({tg, "_hold_pre"},   pre_spike,  e_pre);
      check({tg, "_hold_post"},  post_spike, e_post);
    end
    stdp_wait = 1'b0;
    @(posedge clk); #1;
    stdp_wait = 1'b1;
    check({tg, "_accepted"}, {7'd0, req_valid}, 8'd0);
    resp_valid = 1'b1; updated_weight = rv;
    @(posedge clk); #1;
    resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 0; pre_fire = '0; post_fire = 0; wload_en = 0;
    wload_addr = '0; wload_data = '0; rd_addr = '0; stdp_wait = 1'b1;
    resp_valid = 0; updated_weight = '0;
    #2;
    check("rst_req_valid", {7'd0, req_valid},   8'd0);
    check("rst_busy",      {7'd0, busy},        8'd0);
    check("rst_ready",     {7'd0, wload_ready}, 8'd1);
    check("rst_overflow",  {7'd0, overflow},    8'd0);
    check("rst_pre_spike", pre_spike, 8'd0);
    check("rst_rd_data",   rd_data,   8'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Weight loads; read shows the new value only after the edge
    wload_en = 1'b1; wload_addr = 3'd3; wload_data = 8'h10; rd_addr = 3'd3;
    #1;
    check("rd_before_edge", rd_data, 8'h00);
    @(posedge clk); #1;
    wload_en = 1'b0;
    check("rd_after_edge", rd_data, 8'h10);
    load(3'd5, 8'h55);

    // Pre on input 3 at now=10, post at now=15
    idle_ticks(10);
    step(8'h08, 1'b0);
    idle_ticks(4);
    step(8'h00, 1'b1);
    check("sc1_busy", {7'd0, busy}, 8'd1);
    repeat (3) @(posedge clk);
    #1;
    check("sc1_scan_lat0", {7'd0, req_valid}, 8'd0);
    @(posedge clk); #1;
    check("sc1_scan_lat1", {7'd0, req_valid}, 8'd1);
    serve("sc1", 8'd11, 8'd16, 8'd3, 8'h10, 8'h42, 1);
    wait_idle("sc1");
    rd_addr = 3'd3; #1;
    check("sc1_w3", rd_data, 8'h42);
    check("sc1_reqs", 8'(req_cnt), 8'd1);

    // Ages 21 (input 1) and 5 (input 5) with WINDOW=20; now starts at 16
    step(8'h02, 1'b0);
    idle_ticks(15);
    step(8'h20, 1'b0);
    idle_ticks(4);
    step(8'h00, 1'b1);
    serve("sc2", 8'd33, 8'd38, 8'd5, 8'h55, 8'h66, 1);
    wait_idle("sc2");
    check("sc2_reqs", 8'(req_cnt), 8'd2);
    rd_addr = 3'd5; #1;
    check("sc2_w5", rd_data, 8'h66);
    rd_addr = 3'd1; #1;
    check("sc2_w1", rd_data, 8'h00);

    // Timestamp wrap: pre at now=253, post at now=2; engine stalls 7 cycles
    idle_ticks(215);
    step(8'h04, 1'b0);
    idle_ticks(4);
    step(8'h00, 1'b1);
    serve("sc3", 8'd254, 8'd3, 8'd2, 8'h00, 8'h33, 7);
    wait_idle("sc3");
    check("sc3_diff", 8'(post_spike - pre_spike), 8'd5);
    rd_addr = 3'd2; #1;
    check("sc3_w2", rd_data, 8'h33);

    // Three extra post events during one transaction; now starts at 3
    idle_ticks(30);
    step(8'h01, 1'b0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    check("sc4_ovf_after_pend", {7'd0, overflow}, 8'd0);
    step(8'h00, 1'b1);
    check("sc4_ovf_set", {7'd0, overflow}, 8'd1);
    step(8'h00, 1'b1);
    check("sc4_ready_busy", {7'd0, wload_ready}, 8'd0);
    load(3'd6, 8'hEE);
    serve("sc4a", 8'd34, 8'd35, 8'd0, 8'h00, 8'h11, 1);
    serve("sc4b", 8'd34, 8'd36, 8'd0, 8'h11, 8'h22, 1);
    wait_idle("sc4");
    repeat (20) @(posedge clk);
    #1;
    check("sc4_reqs", 8'(req_cnt), 8'd5);
    check("sc4_ovf_sticky", {7'd0, overflow}, 8'd1);
    rd_addr = 3'd0; #1;
    check("sc4_w0", rd_data, 8'h22);
    rd_addr = 3'd6; #1;
    check("sc4_busy_load_ignored", rd_data, 8'h00);

    // Reset during RESP; now starts at 38
    load(3'd4, 8'h77);
    idle_ticks(30);
    step(8'h10, 1'b0);
    step(8'h00, 1'b1);
    wait_req("sc5");
    check("sc5_pre", pre_spike, 8'd69);
    check("sc5_w",   weight,    8'h77);
    stdp_wait = 1'b0;
    @(posedge clk); #1;
    stdp_wait = 1'b1;
    check("sc5_in_resp", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    #1;
    check("sc5_rst_busy",     {7'd0, busy},      8'd0);
    check("sc5_rst_req",      {7'd0, req_valid}, 8'd0);
    check("sc5_rst_ovf",      {7'd0, overflow},  8'd0);
    check("sc5_rst_pre",      pre_spike,     8'd0);
    check("sc5_rst_post",     post_spike,    8'd0);
    check("sc5_rst_nn",       neuron_number, 8'd0);
    check("sc5_rst_weight",   weight,        8'd0);
    rd_addr = 3'd4; #1;
    check("sc5_rst_w4", rd_data, 8'h00);
    rst = 1'b0;
    resp_valid = 1'b1; updated_weight = 8'h99;
    repeat (3) @(posedge clk);
    #1;
    resp_valid = 1'b0;
    check("sc5_late_resp_w4", rd_data, 8'h00);
    check("sc5_late_busy", {7'd0, busy}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stdp_pair_scheduler.md
STDP_PAIR_SCHEDULER -- requirements
Module: stdp_pair_scheduler

Interface
REQ-001 SHALL have parameter N_PRE, default 8: number of presynaptic inputs (power of 2, 2..16).
REQ-002 SHALL have parameter WINDOW, default 20: maximum pre-to-post age in ticks eligible for pairing (1..254).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: asynchronous active-high reset.
- tick, in, 1: timestep strobe.
- pre_fire, in, N_PRE: presynaptic spikes; sampled only when tick=1.
- post_fire, in, 1: postsynaptic spike; sampled only when tick=1.
- wload_en, in, 1: weight load strobe.
- wload_addr, in, clog2(N_PRE): weight load index.
- wload_data, in, 8: weight load value.
- wload_ready, out, 1: load accepted this cycle.
- rd_addr, in, clog2(N_PRE): weight read index.
- rd_data, out, 8: combinational weight read.
- req_valid, out, 1: pair request to STDP engine.
- pre_spike, out, 8: pre timestamp.
- post_spike, out, 8: post timestamp.
- weight, out, 8: current weight.
- neuron_number, out, 8: zero-extended pre index.
- stdp_wait, in, 1: engine busy.
- resp_valid, in, 1: updated_weight valid.
- updated_weight, in, 8: new weight.
- busy, out, 1: FSM not IDLE.
- overflow, out, 1: sticky; a post event was dropped.

Function
REQ-005 SHALL keep an 8-bit timestamp now that increments on each tick and wraps 255->0.
REQ-006 SHALL keep an 8-bit saturating age per pre input:
- set to 0 on tick with pre_fire[i]=1;
- otherwise incremented on tick;
- saturates at 255, which means invalid.
REQ-007 On a tick with both pre_fire[i] and post_fire set, the pre update SHALL apply first, so input i pairs with age 0.
REQ-008 On an accepted post event, SHALL snapshot all ages and the post timestamp (now after that tick's increment); later pre_fire SHALL NOT alter an in-progress scan.
REQ-009 FSM states SHALL be IDLE, SCAN, REQ, RESP, WB.
- IDLE->SCAN on post event or pending flag; index i is set to 0.
- SCAN: if snapshot age[i] <= WINDOW go to REQ; otherwise i++, returning to IDLE after i = N_PRE-1.
- SCAN SHALL take one cycle per ineligible index.
REQ-010 In REQ, the block SHALL hold req_valid=1 and stable pre_spike=(post_ts - age[i]) mod 256, post_spike=post_ts, weight=W[i], neuron_number=i. The request is accepted on the first cycle with stdp_wait=0, and the FSM moves to RESP.
REQ-011 RESP SHALL wait indefinitely for resp_valid=1, capture updated_weight, then go to WB.
REQ-012 WB SHALL write W[i]=captured value in one cycle, then do i++ or go to IDLE after the last index.
REQ-013 A post event while busy SHALL set a one-deep pending flag. A further post event while pending is already set SHALL be dropped and SHALL set overflow.
REQ-014 wload_ready SHALL equal (FSM==IDLE). A load with wload_ready=0 SHALL be ignored.
REQ-015 rd_data SHALL show W[rd_addr], including a write done that cycle only after the clock edge.
REQ-016 Outputs other than rd_data SHALL be registered.

Reset
REQ-017 rst=1 SHALL immediately produce:
- FSM=IDLE, now=0, all ages=255, pending=0, overflow=0, all W=0;
- req_valid=0, busy=0, and pre_spike, post_spike, weight, neuron_number all 0.
REQ-018 Reset mid-transaction SHALL abandon it without writeback.

Structure
REQ-019 Package stdp_pkg SHALL hold TS_W=8, AGE_INVALID=255, and the FSM state enum.
REQ-020 Per-input age counters SHALL be one sub-module, stdp_age_tracker, instantiated N_PRE times.

Verification
REQ-021 Scenario: pre_fire[3] at now=10, post_fire at now=15, stdp_wait=0, response 0x42 -> one request with pre_spike=11, post_spike=16, neuron_number=3; W[3]=0x42.
REQ-022 Scenario: pre ages 5 and 21 with WINDOW=20 -> exactly one request, for age 5.
REQ-023 Scenario: pre at now=253, post at now=2 -> pre_spike=254, post_spike=3; the difference mod 256 is 5.
REQ-024 Scenario: stdp_wait held 1 for 7 cycles -> req_valid and its fields are stable for 7 cycles, then accepted.
REQ-025 Scenario: three post events during one scan -> one pending event is served, and overflow=1.
REQ-026 Scenario: rst asserted during RESP -> outputs at reset values immediately, and W is unchanged by the late resp_valid.
